// File: rtl/bdm_target_responder_pkg.sv
// Shared definitions for the BDM target responder: state encoding, default
// slot timing (in clk cycles) and the saturating counter helper.
package bdm_target_responder_pkg;

  localparam int CNT_W = 16;

  localparam int unsigned DEF_SAMPLE_CYC     = 40;
  localparam int unsigned DEF_READ0_HOLD     = 52;
  localparam int unsigned DEF_SYNC_MIN_CYC   = 512;
  localparam int unsigned DEF_SYNC_DELAY_CYC = 64;
  localparam int unsigned DEF_SYNC_PULSE_CYC = 512;
  localparam int unsigned DEF_BIT_TIMEOUT    = 4096;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LOW,
    S_RD_DRIVE,
    S_WAIT_HIGH,
    S_SYNC_WAIT,
    S_SYNC_DRIVE
  } state_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/bdm_bkgd_sync.sv
// Two-flop synchronizer for the raw bkgd pin plus single-cycle rise/fall
// strobes; the pin idles high, so all stages reset to 1.
module bdm_bkgd_sync (
  input  logic clk,
  input  logic rst,
  input  logic bkgd_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  // NOTE: clocked state uses non-blocking assignments so every stage samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= bkgd_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/bdm_target_responder.sv
// Target (MCU) side of the single-wire BDM link: decodes host write slots,
// answers read slots from a loaded byte and replies to SYNC requests.
module bdm_target_responder
  import bdm_target_responder_pkg::*;
#(
  parameter int unsigned SAMPLE_CYC     = DEF_SAMPLE_CYC,
  parameter int unsigned READ0_HOLD     = DEF_READ0_HOLD,
  parameter int unsigned SYNC_MIN_CYC   = DEF_SYNC_MIN_CYC,
  parameter int unsigned SYNC_DELAY_CYC = DEF_SYNC_DELAY_CYC,
  parameter int unsigned SYNC_PULSE_CYC = DEF_SYNC_PULSE_CYC,
  parameter int unsigned BIT_TIMEOUT    = DEF_BIT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bkgd_in,
  output logic       bkgd_out,
  output logic       bkgd_is_high_z,
  output logic [7:0] rx_data,
  output logic       new_rx_data,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_busy,
  output logic       sync_seen
);

  logic pin_level, pin_rise, pin_fall;

  bdm_bkgd_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .bkgd_in (bkgd_in),
    .level   (pin_level),
    .rise    (pin_rise),
    .fall    (pin_fall)
  );

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d, to_q, to_d;
  logic [7:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d, tx_sh_q, tx_sh_d;
  logic [2:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic       new_rx_q, new_rx_d, tx_busy_q, tx_busy_d;
  logic       high_z_q, high_z_d, sync_seen_q, sync_seen_d, sync_arm_q, sync_arm_d;
  cnt_t       cnt_inc, to_inc;
  logic       sync_now, wr_bit;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    to_d        = '0;
    rx_sh_d     = rx_sh_q;
    rx_cnt_d    = rx_cnt_q;
    rx_data_d   = rx_data_q;
    new_rx_d    = 1'b0;
    tx_sh_d     = tx_sh_q;
    tx_cnt_d    = tx_cnt_q;
    tx_busy_d   = tx_busy_q;
    high_z_d    = high_z_q;
    sync_seen_d = 1'b0;
    sync_arm_d  = sync_arm_q;
    cnt_inc     = sat_inc(cnt_q);
    to_inc      = sat_inc(to_q);
    sync_now    = (cnt_inc == cnt_t'(SYNC_MIN_CYC));
    wr_bit      = (cnt_inc < cnt_t'(SAMPLE_CYC));

    // A load in the cycle a fall is detected still sees tx_busy_q=0, so that slot is a write.
    if (tx_load && !tx_busy_q) begin
      tx_sh_d   = tx_data;
      tx_cnt_d  = '0;
      tx_busy_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (pin_fall) begin
          cnt_d = '0;
          if (tx_busy_q) begin
            state_d  = S_RD_DRIVE;
            high_z_d = tx_sh_q[7];
          end else begin
            state_d    = S_WR_LOW;
            sync_arm_d = 1'b0;
          end
        end else if (rx_cnt_q != 3'd0) begin
          to_d = to_inc;
          if (to_inc == cnt_t'(BIT_TIMEOUT)) begin
            rx_cnt_d = '0;
            to_d     = '0;
          end
        end
      end
      S_WR_LOW: begin
        cnt_d = cnt_inc;
        if (sync_now) begin
          sync_seen_d = 1'b1;
          sync_arm_d  = 1'b1;
          rx_cnt_d    = '0;
          tx_busy_d   = 1'b0;
          tx_cnt_d    = '0;
        end
        if (pin_rise) begin
          if (sync_arm_q || sync_now) begin
            state_d = S_SYNC_WAIT;
            cnt_d   = '0;
          end else begin
            state_d  = S_IDLE;
            rx_sh_d  = {rx_sh_q[6:0], wr_bit};
            rx_cnt_d = rx_cnt_q + 3'd1;
            if (rx_cnt_q == 3'd7) begin
              rx_data_d = {rx_sh_q[6:0], wr_bit};
              new_rx_d  = 1'b1;
            end
          end
        end
      end
      S_RD_DRIVE: begin
        // The pin is ours (or deliberately released) here; host edges are ignored.
        cnt_d = cnt_inc;
        if (cnt_inc == cnt_t'(READ0_HOLD)) begin
          state_d  = S_WAIT_HIGH;
          high_z_d = 1'b1;
          tx_sh_d  = {tx_sh_q[6:0], 1'b0};
          tx_cnt_d = tx_cnt_q + 3'd1;
          if (tx_cnt_q == 3'd7) tx_busy_d = 1'b0;
        end
      end
      S_WAIT_HIGH: begin
        if (pin_level) state_d = S_IDLE;
      end
      S_SYNC_WAIT: begin
        if (pin_fall) begin
          state_d    = S_WR_LOW;
          cnt_d      = '0;
          sync_arm_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == cnt_t'(SYNC_DELAY_CYC)) begin
            state_d  = S_SYNC_DRIVE;
            cnt_d    = '0;
            high_z_d = 1'b0;
          end
        end
      end
      S_SYNC_DRIVE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == cnt_t'(SYNC_PULSE_CYC)) begin
          state_d  = S_WAIT_HIGH;
          high_z_d = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        high_z_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      to_q        <= '0;
      rx_sh_q     <= '0;
      rx_cnt_q    <= '0;
      rx_data_q   <= '0;
      new_rx_q    <= 1'b0;
      tx_sh_q     <= '0;
      tx_cnt_q    <= '0;
      tx_busy_q   <= 1'b0;
      high_z_q    <= 1'b1;
      sync_seen_q <= 1'b0;
      sync_arm_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      rx_sh_q     <= rx_sh_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_data_q   <= rx_data_d;
      new_rx_q    <= new_rx_d;
      tx_sh_q     <= tx_sh_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_busy_q   <= tx_busy_d;
      high_z_q    <= high_z_d;
      sync_seen_q <= sync_seen_d;
      sync_arm_q  <= sync_arm_d;
    end
  end

  assign bkgd_out       = 1'b0;
  assign bkgd_is_high_z = high_z_q;
  assign rx_data        = rx_data_q;
  assign new_rx_data    = new_rx_q;
  assign tx_busy        = tx_busy_q;
  assign sync_seen      = sync_seen_q;

endmodule

// File: tb/tb_bdm_target_responder.sv
// Bench for bdm_target_responder: a host model on a wired-AND bkgd line,
// table-driven write bytes scored through a queue, plus read/SYNC/reset sequences.
module tb_bdm_target_responder;

  localparam int READ0_HOLD = 52;
  localparam int SYNC_MIN   = 512;
  localparam int SYNC_DELAY = 64;
  localparam int SYNC_PULSE = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_low = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       bkgd_out, bkgd_is_high_z, new_rx_data, tx_busy, sync_seen;
  logic [7:0] rx_data;
  logic       bkgd;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sync_count = 0;
  int sync_cyc = 0;
  logic [7:0] exp_q[$];

  assign bkgd = host_low ? 1'b0 : (bkgd_is_high_z ? 1'b1 : bkgd_out);

  bdm_target_responder dut (
    .clk            (clk),
    .rst            (rst),
    .bkgd_in        (bkgd),
    .bkgd_out       (bkgd_out),
    .bkgd_is_high_z (bkgd_is_high_z),
    .rx_data        (rx_data),
    .new_rx_data    (new_rx_data),
    .tx_data        (tx_data),
    .tx_load        (tx_load),
    .tx_busy        (tx_busy),
    .sync_seen      (sync_seen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each strobed byte must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && new_rx_data) begin
      if (exp_q.size() == 0) check("rx_unexpected_strobe", {24'h0, rx_data}, 32'hFFFF_FFFF);
      else check("rx_byte", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
    end
    if (!rst && sync_seen) begin
      sync_count++;
      sync_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic host_slot(input int low_len, input int gap);
    @(negedge clk);
    host_low = 1'b1;
    repeat (low_len) @(negedge clk);
    host_low = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic host_write_byte(input logic [7:0] v, input int len1, input int len0);
    for (int i = 7; i >= 0; i--) host_slot(v[i] ? len1 : len0, 20);
  endtask

  // Read slot: 8-clk host pulse, pin sampled 40 clk after the fall.
  task automatic host_read_byte(input logic [7:0] exp, input string tag);
    logic [7:0] got;
    int drv;
    for (int b = 7; b >= 0; b--) begin
      drv = 0;
      @(negedge clk);
      host_low = 1'b1;
      for (int k = 1; k <= 90; k++) begin
        @(negedge clk);
        if (!bkgd_is_high_z) drv++;
        if (k == 8) host_low = 1'b0;
        if (k == 40) got[b] = bkgd;
      end
      check({tag, "_drive_len"}, drv, exp[b] ? 0 : READ0_HOLD);
      if (b == 1) check({tag, "_busy_before_last"}, {31'h0, tx_busy}, 1);
    end
    check({tag, "_byte"}, {24'h0, got}, {24'h0, exp});
    check({tag, "_busy_after"}, {31'h0, tx_busy}, 0);
  endtask

  task automatic load_tx(input logic [7:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  typedef struct {
    logic [7:0] pattern;
    int         len1;
    int         len0;
    logic [7:0] exp;
  } wr_vec_t;

  wr_vec_t vecs[6];

  initial begin
    int c0, rel, n;

    vecs[0] = '{8'hA5, 16, 60, 8'hA5};
    vecs[1] = '{8'h5A, 16, 60, 8'h5A};
    vecs[2] = '{8'hA5, 39, 40, 8'hA5};
    vecs[3] = '{8'h0F, 16, 39, 8'hFF};
    vecs[4] = '{8'h0F, 40, 60, 8'h00};
    vecs[5] = '{8'hC3,  2, 120, 8'hC3};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_high_z", {31'h0, bkgd_is_high_z}, 1);
    check("rst_bkgd_out", {31'h0, bkgd_out}, 0);
    check("rst_rx_data", {24'h0, rx_data}, 0);
    check("rst_new_rx", {31'h0, new_rx_data}, 0);
    check("rst_tx_busy", {31'h0, tx_busy}, 0);
    check("rst_sync_seen", {31'h0, sync_seen}, 0);

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].exp);
      host_write_byte(vecs[i].pattern, vecs[i].len1, vecs[i].len0);
    end
    repeat (10) @(negedge clk);
    check("wr_queue_drained", exp_q.size(), 0);

    load_tx(8'h3C);
    check("tx_busy_after_load", {31'h0, tx_busy}, 1);
    host_read_byte(8'h3C, "rd3c");

    load_tx(8'h11);
    load_tx(8'h22);
    host_read_byte(8'h11, "rd_busy_load");

    // SYNC: host holds the line low for 600 clk.
    @(negedge clk);
    c0 = cyc;
    n = sync_count;
    host_low = 1'b1;
    repeat (600) @(negedge clk);
    host_low = 1'b0;
    rel = cyc;
    check("sync_seen_count", sync_count - n, 1);
    check("sync_seen_time", sync_cyc - c0, SYNC_MIN + 3);
    n = 0;
    while (bkgd_is_high_z && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sync_reply_delay", cyc - rel, SYNC_DELAY + 3);
    n = 0;
    while (!bkgd_is_high_z && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("sync_pulse_len", n, SYNC_PULSE);
    repeat (10) @(negedge clk);

    // Partial byte (3 bits) must be dropped by the idle timeout.
    host_slot(16, 20);
    host_slot(60, 20);
    host_slot(16, 20);
    repeat (4200) @(negedge clk);
    exp_q.push_back(8'hFF);
    host_write_byte(8'hFF, 16, 60);
    repeat (10) @(negedge clk);
    check("timeout_queue_drained", exp_q.size(), 0);
    check("timeout_rx_data", {24'h0, rx_data}, 32'hFF);

    // Reset while the target is holding the pin low for a read-0.
    load_tx(8'h00);
    @(negedge clk);
    host_low = 1'b1;
    repeat (8) @(negedge clk);
    host_low = 1'b0;
    repeat (4) @(negedge clk);
    check("rd_driving_before_rst", {31'h0, bkgd_is_high_z}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_releases_pin", {31'h0, bkgd_is_high_z}, 1);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_tx_busy", {31'h0, tx_busy}, 0);
    check("rst_mid_rx_data", {24'h0, rx_data}, 0);
    repeat (10) @(negedge clk);
    check("pin_stays_released", {31'h0, bkgd_is_high_z}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
